dis_fe_arb: RTL

- Shares the single front-end (FE) Avalon read port among NREQ display channels, e.g. two 340 units, or a 340 plus a point-plot unit.
- Each channel raises its FE data request with a 32-bit point word. The arbiter grants channels round-robin, buffers granted words in a small FIFO, and returns a one-cycle acknowledge that the channel treats as its FE read (clearing its request and resuming its intensify delay).
- The FE host reads the FIFO head through the Avalon slave.

---
 rtl/dis_fe_pkg.sv | 17 +
 rtl/dis_fe_fifo.sv | 56 +++++
 rtl/dis_fe_arb.sv | 89 ++++++++
 3 files changed

// File: rtl/dis_fe_pkg.sv
// Shared field positions of the 32-bit front-end point word and channel limits.
// Word layout: {valid, tag[2:0], 5'b0, i[2:0], y[9:0], x[9:0]}.
package dis_fe_pkg;

  localparam int FE_VALID_BIT = 31;
  localparam int FE_TAG_MSB   = 30;
  localparam int FE_TAG_LSB   = 28;
  localparam int FE_I_MSB     = 22;
  localparam int FE_I_LSB     = 20;
  localparam int FE_Y_MSB     = 19;
  localparam int FE_Y_LSB     = 10;
  localparam int FE_X_MSB     = 9;
  localparam int FE_X_LSB     = 0;

  localparam int FE_MAX_REQ   = 8;

endpackage

// File: rtl/dis_fe_fifo.sv
// DEPTH x 32 synchronous FIFO with a combinational head (zero when empty).
// A push while full is accepted only if a pop happens in the same cycle; flush wins over both.
module dis_fe_fifo #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [31:0]   push_data,
  input  logic          pop,
  input  logic          flush,
  output logic [31:0]   head,
  output logic [LW-1:0] level
);

  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && (level != '0);
  assign do_push = push && ((level != FULL) || do_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset: the head is masked by level.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head = (level != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/dis_fe_arb.sv
// Round-robin arbiter sharing the FE read port among NREQ display channels.
// One grant per cycle into a DEPTH-word FIFO; the winner gets a one-cycle ack on the next cycle.
module dis_fe_arb
  import dis_fe_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int DEPTH = 4,
  parameter int TAG   = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     flush,
  input  logic [NREQ-1:0]          rq,
  input  logic [32*NREQ-1:0]       rq_data,
  output logic [NREQ-1:0]          ack,
  input  logic                     s_read,
  output logic [31:0]              s_readdata,
  output logic                     fe_data_rq,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  logic [IW-1:0]   rr;
  logic [IW-1:0]   win;
  logic            found;
  logic [NREQ-1:0] elig;
  logic            space;
  logic            grant;
  logic [31:0]     word;
  logic [NREQ-1:0] ack_nxt;

  // A channel whose ack is high has not yet dropped rq, so it is masked out.
  assign elig  = rq & ~ack;
  assign space = (level != FULL) || s_read;
  assign grant = enable && !flush && found && space;

  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!found && elig[i] && (((int'(rr) + k) % NREQ) == i)) begin
          found = 1'b1;
          win   = IW'(i);
        end
      end
    end
  end

  always_comb begin
    word    = '0;
    ack_nxt = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == IW'(i)) word = rq_data[32*i +: 32];
      ack_nxt[i] = grant && (win == IW'(i));
    end
    word[FE_VALID_BIT] = 1'b1;
    if (TAG != 0) word[FE_TAG_MSB:FE_TAG_LSB] = 3'(win);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr  <= '0;
      ack <= '0;
    end else begin
      ack <= ack_nxt;
      if (flush)      rr <= '0;
      else if (grant) rr <= (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;
    end
  end

  dis_fe_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (grant),
    .push_data (word),
    .pop       (s_read),
    .flush     (flush),
    .head      (s_readdata),
    .level     (level)
  );

  assign fe_data_rq = (level != '0);

endmodule
